// File: rtl/mist_spi_pkg.sv
// Shared types for the MiST SPI master: FSM states, select codes and the select decoder.
package mist_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_RELEASE,
        ST_GAP
    } spi_state_e;

    localparam logic [1:0] SEL_USER_IO = 2'd0;
    localparam logic [1:0] SEL_DATA_IO = 2'd1;
    localparam logic [1:0] SEL_OSD     = 2'd2;
    localparam logic [1:0] SEL_SD      = 2'd3;

    // Active-low select vector with exactly one bit low, indexed by select code.
    function automatic logic [3:0] sel_to_cs_n(input logic [1:0] sel);
        logic [3:0] cs_n;
        cs_n      = 4'b1111;
        cs_n[sel] = 1'b0;
        return cs_n;
    endfunction

endpackage

// File: rtl/mist_spi_clk_div.sv
// SCK half-period tick generator: tick is high in the last cycle of every CLK_DIV-cycle window.
// Cleared on byte acceptance so every byte starts on the same phase; frozen while en is low.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mist_spi_master.sv
// Byte-wide mode-0 SPI master for the MiST IO controller; rx byte 16*CLK_DIV+1 cycles after accept.
// tx_ready only in IDLE/HOLD; select held across HOLD so multi-byte frames keep one select low.
module mist_spi_master
    import mist_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic [1:0] tx_sel,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       SPI_SCK,
    output logic       SPI_DI,
    input  logic       SPI_DO,
    output logic       CONF_DATA0,
    output logic       SPI_SS2,
    output logic       SPI_SS3,
    output logic       SPI_SS4
);

    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    spi_state_e state_q, state_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] gap_q, gap_d;
    logic [3:0] half_q, half_d;
    logic [3:0] cs_n_q, cs_n_d;
    logic       sck_q, sck_d;
    logic       di_q, di_d;
    logic       last_q, last_d;
    logic       tx_ready_q, tx_ready_d;
    logic       rx_valid_q, rx_valid_d;
    logic       accept;
    logic       tick;
    logic       div_en;

    assign accept = tx_valid && tx_ready_q;
    assign div_en = (state_q == ST_SHIFT) || (state_q == ST_RELEASE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .clr   (accept),
        .en    (div_en),
        .tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        gap_d      = gap_q;
        half_d     = half_q;
        cs_n_d     = cs_n_q;
        sck_d      = sck_q;
        di_d       = di_q;
        last_d     = last_q;
        rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    // A HOLD acceptance continues the open frame on its original select.
                    if (state_q == ST_IDLE) begin
                        cs_n_d = sel_to_cs_n(tx_sel);
                    end
                    state_d = ST_SHIFT;
                    tx_sh_d = tx_data;
                    di_d    = tx_data[7];
                    last_d  = tx_last;
                    half_d  = 4'd0;
                    sck_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    half_d = half_q + 4'd1;
                    sck_d  = ~sck_q;
                    if (sck_q) begin
                        rx_sh_d = {rx_sh_q[6:0], SPI_DO};
                        if (half_q == 4'd15) begin
                            // Eighth fall: SPI_DI keeps bit 0 while the select stays low.
                            rx_data_d  = {rx_sh_q[6:0], SPI_DO};
                            rx_valid_d = 1'b1;
                            state_d    = last_q ? ST_RELEASE : ST_HOLD;
                        end else begin
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                            di_d    = tx_sh_q[6];
                        end
                    end
                end
            end
            ST_RELEASE: begin
                if (tick) begin
                    cs_n_d  = 4'b1111;
                    gap_d   = 8'd0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            tx_sh_q    <= 8'd0;
            rx_sh_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            gap_q      <= 8'd0;
            half_q     <= 4'd0;
            cs_n_q     <= 4'b1111;
            sck_q      <= 1'b0;
            di_q       <= 1'b0;
            last_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            gap_q      <= gap_d;
            half_q     <= half_d;
            cs_n_q     <= cs_n_d;
            sck_q      <= sck_d;
            di_q       <= di_d;
            last_q     <= last_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign SPI_SCK    = sck_q;
    assign SPI_DI     = di_q;
    assign CONF_DATA0 = cs_n_q[SEL_USER_IO];
    assign SPI_SS2    = cs_n_q[SEL_DATA_IO];
    assign SPI_SS3    = cs_n_q[SEL_OSD];
    assign SPI_SS4    = cs_n_q[SEL_SD];

endmodule

// File: tb/tb_mist_spi_master.sv
// Bench for mist_spi_master: two instances (CLK_DIV 4 and 2), a reactive mode-0 slave and a
// cycle-by-cycle reference built from the byte timing formulas.
module tb_mist_spi_master;

    localparam int G = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'd0;
    logic [1:0] tx_sel   = 2'd0;
    logic       tx_last  = 1'b0;
    logic       SPI_DO;
    logic       use2     = 1'b0;

    logic       tv4, rdy4, rxv4, bsy4, sck4, di4, c0_4, s2_4, s3_4, s4_4;
    logic       tv2, rdy2, rxv2, bsy2, sck2, di2, c0_2, s2_2, s3_2, s4_2;
    logic [7:0] rxd4, rxd2;

    logic       sck, di, rdy, rxv, bsy;
    logic [7:0] rxd;
    logic [3:0] cs;

    int         checks = 0;
    int         errors = 0;
    int         D = 4;
    logic       in_frame = 1'b0;
    logic [1:0] frame_sel = 2'd0;
    logic [7:0] last_rx = 8'd0;

    logic [7:0] slv_resp = 8'd0;
    logic [2:0] slv_cnt;
    logic       sck_prev;

    always #5 CLOCK_50 = ~CLOCK_50;

    assign tv4 = tx_valid && !use2;
    assign tv2 = tx_valid && use2;

    mist_spi_master #(.CLK_DIV(4), .CS_GAP(G)) u_dut4 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .tx_valid(tv4), .tx_ready(rdy4),
        .tx_data(tx_data), .tx_sel(tx_sel), .tx_last(tx_last), .rx_valid(rxv4),
        .rx_data(rxd4), .busy(bsy4), .SPI_SCK(sck4), .SPI_DI(di4), .SPI_DO(SPI_DO),
        .CONF_DATA0(c0_4), .SPI_SS2(s2_4), .SPI_SS3(s3_4), .SPI_SS4(s4_4)
    );

    mist_spi_master #(.CLK_DIV(2), .CS_GAP(G)) u_dut2 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .tx_valid(tv2), .tx_ready(rdy2),
        .tx_data(tx_data), .tx_sel(tx_sel), .tx_last(tx_last), .rx_valid(rxv2),
        .rx_data(rxd2), .busy(bsy2), .SPI_SCK(sck2), .SPI_DI(di2), .SPI_DO(SPI_DO),
        .CONF_DATA0(c0_2), .SPI_SS2(s2_2), .SPI_SS3(s3_2), .SPI_SS4(s4_2)
    );

    assign sck = use2 ? sck2 : sck4;
    assign di  = use2 ? di2  : di4;
    assign rdy = use2 ? rdy2 : rdy4;
    assign rxv = use2 ? rxv2 : rxv4;
    assign bsy = use2 ? bsy2 : bsy4;
    assign rxd = use2 ? rxd2 : rxd4;
    assign cs  = use2 ? {s4_2, s3_2, s2_2, c0_2} : {s4_4, s3_4, s2_4, c0_4};

    // Slave: presents the current response MSB first and advances one bit per observed SCK fall.
    assign SPI_DO = slv_resp[3'd7 - slv_cnt];

    always @(negedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            slv_cnt  <= 3'd0;
            sck_prev <= 1'b0;
        end else begin
            sck_prev <= sck;
            if (sck_prev && !sck) slv_cnt <= slv_cnt + 3'd1;
        end
    end

    // One byte, checked every cycle from acceptance until HOLD (+hold cycles) or back in IDLE.
    task automatic run_byte(input logic [7:0] data, input logic [1:0] sel, input logic last,
                            input logic [7:0] resp, input int hold, input bit spam);
        int         wait_n;
        int         last_c;
        int         idx;
        logic       exp_sck, exp_di, exp_rxv, exp_rdy, exp_bsy;
        logic [3:0] exp_cs;
        slv_resp = resp;
        tx_data  = data;
        tx_sel   = sel;
        tx_last  = last;
        tx_valid = 1'b1;
        wait_n   = 0;
        while (rdy !== 1'b1 && wait_n < 200) begin
            @(negedge CLOCK_50);
            wait_n++;
        end
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout tx_ready=%b required 1", rdy);
            tx_valid = 1'b0;
            return;
        end
        if (!in_frame) frame_sel = sel;
        in_frame = !last;
        @(posedge CLOCK_50);
        #1;
        tx_valid = spam;
        if (spam) begin
            tx_data = 8'($urandom);
            tx_sel  = 2'($urandom);
            tx_last = 1'($urandom);
        end
        last_c = last ? 17 * D + G + 1 : 16 * D + 1 + hold;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge CLOCK_50);
            if (c <= 16 * D) begin
                exp_sck = (((c - 1) / D) % 2) == 1;
                idx     = (c - 1) / (2 * D);
                exp_di  = data[7 - idx];
            end else begin
                exp_sck = 1'b0;
                exp_di  = data[0];
            end
            exp_rxv = (c == 16 * D + 1);
            if (exp_rxv) last_rx = resp;
            exp_cs  = (!last || c <= 17 * D) ? ~(4'b0001 << frame_sel) : 4'b1111;
            exp_rdy = (c <= 16 * D) ? 1'b0 : (!last ? 1'b1 : (c == 17 * D + G + 1));
            exp_bsy = !(last && c == 17 * D + G + 1);
            checks += 7;
            if (sck !== exp_sck) begin
                errors++; $display("FAIL sck c=%0d got %b want %b", c, sck, exp_sck);
            end
            if (di !== exp_di) begin
                errors++; $display("FAIL spi_di c=%0d got %b want %b", c, di, exp_di);
            end
            if (rxv !== exp_rxv) begin
                errors++; $display("FAIL rx_valid c=%0d got %b want %b", c, rxv, exp_rxv);
            end
            if (rxd !== last_rx) begin
                errors++; $display("FAIL rx_data c=%0d got %h want %h", c, rxd, last_rx);
            end
            if (cs !== exp_cs) begin
                errors++; $display("FAIL selects c=%0d got %b want %b", c, cs, exp_cs);
            end
            if (rdy !== exp_rdy) begin
                errors++; $display("FAIL tx_ready c=%0d got %b want %b", c, rdy, exp_rdy);
            end
            if (bsy !== exp_bsy) begin
                errors++; $display("FAIL busy c=%0d got %b want %b", c, bsy, exp_bsy);
            end
            if (c == 16 * D) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks += 7;
        if (sck !== 1'b0)     begin errors++; $display("FAIL rst_sck got %b want 0", sck); end
        if (di !== 1'b0)      begin errors++; $display("FAIL rst_di got %b want 0", di); end
        if (cs !== 4'b1111)   begin errors++; $display("FAIL rst_selects got %b want 1111", cs); end
        if (rdy !== 1'b0)     begin errors++; $display("FAIL rst_tx_ready got %b want 0", rdy); end
        if (rxv !== 1'b0)     begin errors++; $display("FAIL rst_rx_valid got %b want 0", rxv); end
        if (rxd !== 8'h00)    begin errors++; $display("FAIL rst_rx_data got %h want 00", rxd); end
        if (bsy !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b want 0", bsy); end
        RESET_N = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL rdy_before_edge got %b want 0", rdy); end
        @(negedge CLOCK_50);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL rdy_first_edge got %b want 1", rdy); end
        in_frame = 1'b0;
        last_rx  = 8'h00;
    endtask

    task automatic test_single_byte();
        run_byte(8'hA5, 2'd0, 1'b1, 8'h3C, 0, 1'b0);
    endtask

    task automatic test_hold_frame();
        run_byte(8'h01, 2'd1, 1'b0, 8'($urandom), 2, 1'b0);
        run_byte(8'h02, 2'd3, 1'b0, 8'($urandom), 0, 1'b0);
        run_byte(8'h03, 2'd3, 1'b1, 8'($urandom), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_byte(8'($urandom), 2'd2, 1'b1, 8'($urandom), 0, 1'b0);
        run_byte(8'($urandom), 2'd3, 1'b1, 8'($urandom), 0, 1'b0);
    endtask

    task automatic test_random(input int n_frames);
        int         len;
        logic [1:0] sel;
        for (int f = 0; f < n_frames; f++) begin
            len = $urandom_range(1, 3);
            sel = 2'($urandom);
            for (int b = 0; b < len; b++) begin
                run_byte(8'($urandom), (b == 0) ? sel : 2'($urandom), b == len - 1,
                         8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset_midframe();
        int wait_n;
        slv_resp = 8'($urandom);
        tx_data  = 8'($urandom);
        tx_sel   = 2'd2;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        wait_n   = 0;
        while (rdy !== 1'b1 && wait_n < 200) begin
            @(negedge CLOCK_50);
            wait_n++;
        end
        @(posedge CLOCK_50);
        #1;
        tx_valid = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        #2;
        RESET_N = 1'b0;
        #1;
        checks += 5;
        if (cs !== 4'b1111) begin errors++; $display("FAIL abort_selects got %b want 1111", cs); end
        if (sck !== 1'b0)   begin errors++; $display("FAIL abort_sck got %b want 0", sck); end
        if (rdy !== 1'b0)   begin errors++; $display("FAIL abort_tx_ready got %b want 0", rdy); end
        if (rxv !== 1'b0)   begin errors++; $display("FAIL abort_rx_valid got %b want 0", rxv); end
        if (bsy !== 1'b0)   begin errors++; $display("FAIL abort_busy got %b want 0", bsy); end
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("FAIL abort_rdy_before_edge got %b want 0", rdy); end
        @(negedge CLOCK_50);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL abort_rdy_first_edge got %b want 1", rdy); end
        for (int c = 0; c < 80; c++) begin
            @(negedge CLOCK_50);
            checks++;
            if (rxv !== 1'b0 || cs !== 4'b1111) begin
                errors++;
                $display("FAIL abort_quiet c=%0d rx_valid=%b selects=%b want 0 1111", c, rxv, cs);
            end
        end
        in_frame = 1'b0;
        last_rx  = 8'h00;
    endtask

    task automatic test_div2();
        use2 = 1'b1;
        D    = 2;
        last_rx = rxd2;
        run_byte(8'hFF, 2'd1, 1'b1, 8'h00, 0, 1'b1);
        test_random(3);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_hold_frame();
        test_back_to_back();
        test_random(6);
        test_reset_midframe();
        test_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
